// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch job scheduler and alignment grid:
// FSM states, traceback direction codes, default scoring weights and sizes.
package nw_pkg;

    // Default geometry of one alignment job.
    localparam int NW_LENGTH = 10;
    localparam int NW_CWIDTH = 2;
    localparam int NW_SWIDTH = 16;

    // Default scoring weights used by the grid cells.
    localparam int NW_MATCH    = 1;
    localparam int NW_INDEL    = -1;
    localparam int NW_MISMATCH = -1;

    // Traceback direction codes stored per grid cell.
    typedef enum logic [1:0] {
        DIR_TOP    = 2'b00,
        DIR_LEFT   = 2'b01,
        DIR_CORNER = 2'b10
    } nw_dir_e;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } nw_state_e;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int nw_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/nw_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// wrapping modulo NREQ. Purely combinational; ptr must be below NREQ.
module nw_rr_arbiter
    import nw_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = nw_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan candidates in priority order starting at ptr; the first hit wins.
    always_comb begin
        int  cand;
        logic hit;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand        = (int'(ptr) + k) % NREQ;
            hit         = !any && req[cand];
            grant[cand] = hit;
            idx         = hit ? cand[IDW-1:0] : idx;
            any         = any | hit;
        end
    end

endmodule

// File: rtl/nw_job_scheduler.sv
// Job scheduler in front of a Needleman-Wunsch alignment grid. Accepts one job
// at a time from NREQ requesters (round-robin), clears the grid, waits for the
// grid to finish or for a cycle budget to expire, and returns the score.
module nw_job_scheduler
    import nw_pkg::*;
#(
    parameter int LENGTH     = NW_LENGTH,
    parameter int CWIDTH     = NW_CWIDTH,
    parameter int SWIDTH     = NW_SWIDTH,
    parameter int NREQ       = 2,
    parameter int TMO_CYCLES = 8 * LENGTH,
    parameter int IDW        = nw_width(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0] req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0] req_s2,
    output logic [LENGTH*CWIDTH-1:0]      grid_s1,
    output logic [LENGTH*CWIDTH-1:0]      grid_s2,
    output logic                          grid_clear,
    input  logic                          grid_valid,
    input  logic signed [SWIDTH-1:0]      grid_score,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic signed [SWIDTH-1:0]      rsp_score,
    output logic                          rsp_err,
    output logic                          busy
);

    localparam int SW   = LENGTH * CWIDTH;
    localparam int CNTW = nw_width(TMO_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TMO_CYCLES - 1);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

    nw_state_e                 state_r;
    nw_state_e                 state_next;
    logic [IDW-1:0]            ptr_r;
    logic [CNTW-1:0]           cnt_r;
    logic [SW-1:0]             grid_s1_r;
    logic [SW-1:0]             grid_s2_r;
    logic [IDW-1:0]            rsp_id_r;
    logic signed [SWIDTH-1:0]  rsp_score_r;
    logic                      rsp_err_r;

    logic [NREQ-1:0]           grant_s;
    logic [IDW-1:0]            win_idx_s;
    logic                      any_s;
    logic                      accept_s;
    logic                      timeout_s;
    logic [SW-1:0]             win_s1_s;
    logic [SW-1:0]             win_s2_s;

    nw_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (win_idx_s),
        .any   (any_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && any_s;
    assign timeout_s = (cnt_r == CNT_LAST);

    // Select the winner's strings with an AND-OR mux driven by the one-hot grant.
    always_comb begin
        win_s1_s = '0;
        win_s2_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_s1_s = win_s1_s | (req_s1[i*SW +: SW] & {SW{grant_s[i]}});
            win_s2_s = win_s2_s | (req_s2[i*SW +: SW] & {SW{grant_s[i]}});
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // FSM next-state logic; grid_valid beats a coincident timeout.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_next = ST_CLEAR;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR:  state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_RUN;
            ST_RUN: begin
                if (grid_valid || timeout_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job datapath: latch the accepted job, run the timeout counter, capture the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r       <= '0;
            cnt_r       <= '0;
            grid_s1_r   <= '0;
            grid_s2_r   <= '0;
            rsp_id_r    <= '0;
            rsp_score_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        grid_s1_r <= win_s1_s;
                        grid_s2_r <= win_s2_s;
                        rsp_id_r  <= win_idx_s;
                        ptr_r     <= (win_idx_s == ID_LAST) ? '0 : win_idx_s + IDW'(1);
                    end
                end
                ST_SETTLE: begin
                    cnt_r <= '0;
                end
                ST_RUN: begin
                    if (grid_valid) begin
                        rsp_score_r <= grid_score;
                        rsp_err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_score_r <= '0;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Outputs decode straight from registers; req_ready is gated by reset so it
    // stays low while reset is held even if requests are pending.
    assign grid_s1    = grid_s1_r;
    assign grid_s2    = grid_s2_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_score  = rsp_score_r;
    assign rsp_err    = rsp_err_r;
    assign grid_clear = (state_r == ST_CLEAR);
    assign rsp_valid  = (state_r == ST_DONE);
    assign busy       = (state_r != ST_IDLE);
    assign req_ready  = ((state_r == ST_IDLE) && reset) ? grant_s : '0;

endmodule

// File: tb/tb_nw_job_scheduler.sv
// Directed bench for nw_job_scheduler with a behavioural grid stub.
module tb_nw_job_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [15:0]        req_s1;
    logic [15:0]        req_s2;
    logic [7:0]         grid_s1;
    logic [7:0]         grid_s2;
    logic               grid_clear;
    logic               grid_valid;
    logic signed [15:0] grid_score;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic signed [15:0] rsp_score;
    logic               rsp_err;
    logic               busy;

    int    checks = 0;
    int    errors = 0;
    string cur = "init";

    // Grid stub: since_clr is 0 in SETTLE, 1 in RUN counter 0, and so on.
    int          stub_at = -1;
    bit          stub_stale = 1'b0;
    logic [15:0] stub_score = 16'h0000;
    int          since_clr = 100;

    nw_job_scheduler #(
        .LENGTH     (4),
        .CWIDTH     (2),
        .SWIDTH     (16),
        .NREQ       (2),
        .TMO_CYCLES (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_s1     (req_s1),
        .req_s2     (req_s2),
        .grid_s1    (grid_s1),
        .grid_s2    (grid_s2),
        .grid_clear (grid_clear),
        .grid_valid (grid_valid),
        .grid_score (grid_score),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_score  (rsp_score),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stub timing: count cycles since the grid was cleared.
    always @(posedge clk) begin
        since_clr <= grid_clear ? 0 : ((since_clr < 1000) ? since_clr + 1 : since_clr);
    end

    // A stale completion with a bogus score is shown during SETTLE when requested.
    assign grid_valid = (stub_stale && since_clr == 0) || (stub_at >= 0 && since_clr - 1 >= stub_at);
    assign grid_score = (since_clr == 0) ? 16'h7777 : stub_score;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  s1_0;
        logic [7:0]  s2_0;
        logic [7:0]  s1_1;
        logic [7:0]  s2_1;
        int          stub_at;
        bit          stale;
        logic [15:0] score;
        bit          hold;
        logic [1:0]  exp_ready;
        logic        exp_id;
        logic [7:0]  exp_s1;
        logic [7:0]  exp_s2;
        logic [15:0] exp_score;
        logic        exp_err;
        int          exp_lat;
    } job_t;

    job_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    // Called at the negedge of cycle 1; returns the accept-to-response latency.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Called at a negedge while the DUT is IDLE; ends at the negedge of the next IDLE cycle.
    task automatic run_job(input job_t v);
        int lat;
        req_s1     = {v.s1_1, v.s1_0};
        req_s2     = {v.s2_1, v.s2_0};
        stub_at    = v.stub_at;
        stub_stale = v.stale;
        stub_score = v.score;
        req_valid  = v.req;
        #1;
        chk("ready", 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        @(negedge clk);
        chk("clear", 32'(grid_clear), 32'd1);
        chk("ready_pulse", 32'(req_ready), 32'd0);
        chk("grid_s1", 32'(grid_s1), 32'(v.exp_s1));
        if (!v.hold) begin
            req_valid = 2'b00;
        end
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("id", 32'(rsp_id), 32'(v.exp_id));
        chk("score", {16'h0000, rsp_score}, {16'h0000, v.exp_score});
        chk("err", 32'(rsp_err), 32'(v.exp_err));
        chk("grid_s2", 32'(grid_s2), 32'(v.exp_s2));
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;

        //         req    s1_0   s2_0   s1_1   s2_1  at stl score    hold rdy    id    es1    es2    escore   eerr lat
        tbl[0]  = '{2'b01, 8'h1B, 8'h1B, 8'h00, 8'h00, 5, 1'b0, 16'h0004, 1'b0, 2'b01, 1'b0, 8'h1B, 8'h1B, 16'h0004, 1'b0, 9};
        tbl[1]  = '{2'b10, 8'h00, 8'h00, 8'hE4, 8'h27, 0, 1'b0, 16'hFFFD, 1'b0, 2'b10, 1'b1, 8'hE4, 8'h27, 16'hFFFD, 1'b0, 4};
        tbl[2]  = '{2'b11, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 2, 1'b1, 16'h0007, 1'b1, 2'b01, 1'b0, 8'hA5, 8'h5A, 16'h0007, 1'b0, 6};
        tbl[3]  = '{2'b11, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 1, 1'b0, 16'hFFFF, 1'b1, 2'b10, 1'b1, 8'h3C, 8'hC3, 16'hFFFF, 1'b0, 5};
        tbl[4]  = '{2'b11, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 3, 1'b0, 16'h0002, 1'b1, 2'b01, 1'b0, 8'hA5, 8'h5A, 16'h0002, 1'b0, 7};
        tbl[5]  = '{2'b11, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 0, 1'b0, 16'h0064, 1'b1, 2'b10, 1'b1, 8'h3C, 8'hC3, 16'h0064, 1'b0, 4};
        tbl[6]  = '{2'b10, 8'h00, 8'h00, 8'h0F, 8'hF0, 4, 1'b0, 16'h8000, 1'b0, 2'b10, 1'b1, 8'h0F, 8'hF0, 16'h8000, 1'b0, 8};
        tbl[7]  = '{2'b01, 8'h66, 8'h99, 8'h00, 8'h00, -1, 1'b0, 16'h1234, 1'b0, 2'b01, 1'b0, 8'h66, 8'h99, 16'h0000, 1'b1, 35};
        tbl[8]  = '{2'b01, 8'h2D, 8'hD2, 8'h00, 8'h00, 3, 1'b0, 16'h000C, 1'b0, 2'b01, 1'b0, 8'h2D, 8'hD2, 16'h000C, 1'b0, 7};
        tbl[9]  = '{2'b01, 8'h11, 8'h22, 8'h00, 8'h00, 31, 1'b0, 16'h0009, 1'b0, 2'b01, 1'b0, 8'h11, 8'h22, 16'h0009, 1'b0, 35};
        tbl[10] = '{2'b11, 8'h4B, 8'hB4, 8'h77, 8'h88, 1, 1'b0, 16'h0021, 1'b0, 2'b01, 1'b0, 8'h4B, 8'hB4, 16'h0021, 1'b0, 5};

        // Reset state, with requests pending so req_ready gating is exercised.
        reset     = 1'b0;
        req_valid = 2'b11;
        req_s1    = 16'hFFFF;
        req_s2    = 16'hFFFF;
        rsp_ready = 1'b1;
        #3;
        cur = "reset";
        chk("req_ready", 32'(req_ready), 32'd0);
        chk("busy", 32'(busy), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("grid_clear", 32'(grid_clear), 32'd0);
        chk("grid_s1", 32'(grid_s1), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table: single job, wrap-around arbitration, contention, timeout, coincidence.
        for (int i = 0; i < 10; i++) begin
            cur = $sformatf("row%0d", i);
            run_job(tbl[i]);
        end

        // Backpressure: response held 10 cycles while requester 1 waits.
        cur        = "bp";
        req_s1     = {8'h56, 8'h12};
        req_s2     = {8'h78, 8'h34};
        stub_at    = 0;
        stub_stale = 1'b0;
        stub_score = 16'h0005;
        rsp_ready  = 1'b0;
        req_valid  = 2'b01;
        #1;
        chk("ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'd0);
            chk("hold_score", {16'h0000, rsp_score}, 32'h0005);
            chk("hold_err", 32'(rsp_err), 32'd0);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_grid", 32'(grid_s1), 32'h12);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("still_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("req1_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        chk("req1_grid", 32'(grid_s1), 32'h56);
        wait_rsp(lat);
        chk("req1_latency", 32'(lat), 32'd4);
        chk("req1_id", 32'(rsp_id), 32'd1);
        @(negedge clk);

        // Reset during RUN: outputs clear immediately and the job is dropped.
        cur        = "midrst";
        req_s1     = {8'h00, 8'h9C};
        req_s2     = {8'h00, 8'hC9};
        stub_at    = 10;
        stub_score = 16'h0003;
        req_valid  = 2'b01;
        #1;
        chk("ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("running", 32'(busy), 32'd1);
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("busy", 32'(busy), 32'd0);
        chk("req_ready", 32'(req_ready), 32'd0);
        chk("grid_s1", 32'(grid_s1), 32'd0);
        chk("grid_s2", 32'(grid_s2), 32'd0);
        chk("rsp_id", 32'(rsp_id), 32'd0);
        chk("rsp_score", {16'h0000, rsp_score}, 32'd0);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("grid_clear", 32'(grid_clear), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b1;
        seen      = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || busy) begin
                seen = 1'b1;
            end
        end
        chk("no_response", 32'(seen), 32'd0);

        // First accept after reset favours requester 0.
        cur = "row10";
        run_job(tbl[10]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nw_job_scheduler.md
NW_JOB_SCHEDULER -- requirements
Module: nw_job_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LENGTH, 10, characters per string.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, bits per signed score.
- NREQ, 2, number of requesters (at least 2).
- TMO_CYCLES, 8*LENGTH, RUN-state cycle budget before timeout.
- IDW, max(1, clog2(NREQ)), requester-id width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- req_valid, in, NREQ, per-requester job request.
- req_ready, out, NREQ, per-requester accept strobe.
- req_s1, in, NREQ*LENGTH*CWIDTH, string 1 per requester; slice i belongs to requester i.
- req_s2, in, NREQ*LENGTH*CWIDTH, string 2 per requester.
- grid_s1, out, LENGTH*CWIDTH, string 1 presented to the alignment grid.
- grid_s2, out, LENGTH*CWIDTH, string 2 presented to the alignment grid.
- grid_clear, out, 1, one-cycle clear pulse to the grid.
- grid_valid, in, 1, grid completion flag (score and traceback done).
- grid_score, in, SWIDTH, signed final grid score.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, result consumed.
- rsp_id, out, IDW, requester index owning the result.
- rsp_score, out, SWIDTH, signed captured score.
- rsp_err, out, 1, timeout flag.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, SETTLE, RUN, DONE.
REQ-004 IDLE behaviour:
- If any req_valid is high, the arbiter grants the lowest index at or after ptr, wrapping modulo NREQ.
- req_ready SHALL be one-hot on the winner that cycle, and all zero in every other state.
REQ-005 On the accept cycle (IDLE with a grant):
- Latch the winner's strings into grid_s1/grid_s2 and its index into rsp_id.
- ptr becomes winner+1 modulo NREQ.
- Go to CLEAR.
REQ-006 CLEAR SHALL assert grid_clear for exactly one cycle, then go to SETTLE.
REQ-007 SETTLE SHALL last one cycle and ignore grid_valid (stale value), then go to RUN with the cycle counter at 0.
REQ-008 RUN with grid_valid=1: rsp_score <= grid_score, rsp_err <= 0, go to DONE.
REQ-009 RUN without grid_valid, counter == TMO_CYCLES-1: rsp_score <= 0, rsp_err <= 1, go to DONE.
REQ-010 RUN without grid_valid, counter below TMO_CYCLES-1: counter increments.
REQ-011 If grid_valid and timeout coincide in the same cycle, grid_valid SHALL win.
REQ-012 Latency: with accept at cycle 0, grid_clear is high at cycle 1 and RUN starts at cycle 3. If grid_valid first rises at cycle 3+n, rsp_valid rises at cycle 4+n. Minimum accept-to-response latency is 4 cycles.
REQ-013 DONE handshake:
- DONE holds rsp_valid=1 with rsp_id, rsp_score and rsp_err stable until rsp_ready=1.
- That cycle completes the transfer: rsp_valid drops next cycle and the FSM returns to IDLE.
- No new request is accepted before IDLE.
REQ-014 grid_s1/grid_s2 SHALL stay constant from CLEAR through DONE.
REQ-015 The counter SHALL be wide enough for TMO_CYCLES-1 and SHALL never wrap.
REQ-016 A requester dropping req_valid before it is granted SHALL lose nothing and gain no state.

Reset
REQ-017 While reset is low:
- FSM is IDLE; ptr and counter are 0.
- grid_s1, grid_s2, rsp_id, rsp_score and rsp_err are 0.
- grid_clear, rsp_valid, req_ready and busy are 0.
- These values take effect immediately, without a clock edge.
REQ-018 Reset mid-job SHALL abandon the job with no response; the requester must resubmit.
REQ-019 The first accept after reset release SHALL favour requester 0.

Structure
REQ-020 Shared package nw_pkg SHALL hold:
- the FSM state enum;
- the direction codes TOP=00, LEFT=01, CORNER=10;
- the default MATCH=1, INDEL=-1, MISMATCH=-1 weights;
- the default LENGTH, CWIDTH and SWIDTH.
REQ-021 Round-robin grant logic SHALL be the sub-module nw_rr_arbiter, with inputs req and ptr and a one-hot grant plus encoded index as outputs.

Verification
All scenarios use LENGTH=4, NREQ=2, TMO_CYCLES=32 and a behavioural grid stub.
REQ-022 Single job:
- Stimulus: requester 0 sends s1=s2=8'h1B; the stub raises grid_valid at RUN cycle 5 with score 4.
- Response: grid_clear high at cycle 1; rsp_valid at cycle 9 with id 0, score 4, err 0.
REQ-023 Contention:
- Stimulus: both requesters hold req_valid for 4 jobs; rsp_ready is tied high.
- Response: grants alternate 0,1,0,1; each req_ready pulse lasts exactly one cycle.
REQ-024 Timeout:
- Stimulus: the stub never raises grid_valid.
- Response: rsp_valid at cycle 35 with err 1 and score 0; next job is accepted normally.
REQ-025 Backpressure:
- Stimulus: rsp_ready held low for 10 cycles in DONE; requester 1 keeps requesting.
- Response: rsp fields stable; req_ready stays 0; requester 1 is accepted one cycle after rsp_ready.
REQ-026 Coincidence and reset:
- Stimulus A: grid_valid rises at counter 31. Response: err 0 and the stub's score is returned.
- Stimulus B: reset driven low during RUN. Response: all outputs 0 before the next edge and no response for that job.
